// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/addsub_n.sv
// Parameterized ripple add/sub: s = a + (b ^ op) + op, carry-out on cout.
module addsub_n #(
  parameter int unsigned N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         op,
  output logic [N-1:0] s,
  output logic         cout
);

  logic [N-1:0] bx;
  logic         carry;

  assign bx = b ^ {N{op}};

  // Bit-serial ripple chain; op doubles as the carry-in for subtraction.
  always_comb begin
    s     = '0;
    carry = op;
    for (int i = 0; i < int'(N); i++) begin
      s[i]  = a[i] ^ bx[i] ^ carry;
      carry = (a[i] & bx[i]) | (carry & (a[i] ^ bx[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_start,
  output logic             out_busy,
  output logic             out_done,
  output logic [WIDTH-1:0] out_q,
  output logic [WIDTH-1:0] out_r,
  output logic             out_divz
);

  localparam int unsigned PW    = WIDTH + 1;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q_sr;
  logic [WIDTH-1:0] div_r;
  logic [PW-1:0]    p_r;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             last_step;
  logic [PW-1:0]    p_sh;
  logic [PW-1:0]    trial;
  logic             no_borrow;
  logic [PW-1:0]    p_step;
  logic [WIDTH-1:0] q_step;

  assign accept    = in_start && (state != S_RUN);
  assign last_step = (cnt == CNT_W'(WIDTH - 1));

  // One restoring step: shift {P,Q} left, trial-subtract the divisor.
  assign p_sh = {p_r[WIDTH-1:0], q_sr[WIDTH-1]};

  addsub_n #(.N(PW)) u_sub (
    .a    (p_sh),
    .b    ({1'b0, div_r}),
    .op   (1'b1),
    .s    (trial),
    .cout (no_borrow)
  );

  assign p_step = no_borrow ? trial : p_sh;
  assign q_step = {q_sr[WIDTH-2:0], no_borrow};

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (in_start) state_nxt = (in_b == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (last_step) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (in_start) state_nxt = (in_b == '0) ? S_DONE : S_RUN;
        else          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      q_sr     <= '0;
      div_r    <= '0;
      p_r      <= '0;
      cnt      <= '0;
      out_busy <= 1'b0;
      out_done <= 1'b0;
      out_q    <= '0;
      out_r    <= '0;
      out_divz <= 1'b0;
    end else begin
      state    <= state_nxt;
      out_busy <= (state_nxt == S_RUN);
      out_done <= (state_nxt == S_DONE);
      if (accept) begin
        q_sr     <= in_a;
        div_r    <= in_b;
        p_r      <= '0;
        cnt      <= '0;
        out_divz <= 1'b0;
        // Divide by zero bypasses RUN and publishes results immediately.
        if (in_b == '0) begin
          out_q    <= '1;
          out_r    <= in_a;
          out_divz <= 1'b1;
        end
      end else if (state == S_RUN) begin
        q_sr <= q_step;
        p_r  <= p_step;
        cnt  <= cnt + CNT_W'(1);
        if (last_step) begin
          out_q <= q_step;
          out_r <= p_step[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider with a cycle-level behavioural model.
module tb_seq_divider;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_start = 1'b0;
  logic         out_busy, out_done, out_divz;
  logic [W-1:0] out_q, out_r;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: results and timing derived from a/b, a%b and a countdown.
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic         m_divz = 1'b0;
  logic [W-1:0] m_q = '0;
  logic [W-1:0] m_r = '0;
  logic [W-1:0] pend_q = '0;
  logic [W-1:0] pend_r = '0;
  int           m_left = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_start (in_start),
    .out_busy (out_busy),
    .out_done (out_done),
    .out_q    (out_q),
    .out_r    (out_r),
    .out_divz (out_divz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_loop();
    forever begin
      @(posedge clk);
      if (rst) begin
        m_busy = 1'b0; m_done = 1'b0; m_divz = 1'b0;
        m_q = '0; m_r = '0; m_left = 0;
      end else begin
        m_done = 1'b0;
        if (m_busy) begin
          m_left--;
          if (m_left == 0) begin
            m_busy = 1'b0; m_done = 1'b1; m_q = pend_q; m_r = pend_r;
          end
        end else if (in_start) begin
          m_divz = (in_b == '0);
          if (in_b == '0) begin
            m_done = 1'b1; m_q = '1; m_r = in_a;
          end else begin
            pend_q = in_a / in_b; pend_r = in_a % in_b;
            m_busy = 1'b1; m_left = int'(W);
          end
        end
      end
    end
  endtask

  task automatic compare_loop();
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("cycle_outputs", 32'({out_busy, out_done, out_divz, out_q, out_r}),
          32'({m_busy, m_done, m_divz, m_q, m_r}));
      chk("busy_done_exclusive", 32'(out_busy & out_done), 32'd0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From just after a posedge: count negedges until out_done shows.
  task automatic wait_done(output int lat, output int busy_n);
    bit seen = 1'b0;
    lat = 0;
    busy_n = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (out_busy) busy_n++;
      if (out_done) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int busy_n);
    in_a = a; in_b = b; in_start = 1'b1;
    step();
    in_start = 1'b0;
    in_a = W'($urandom);
    in_b = W'($urandom);
    wait_done(lat, busy_n);
  endtask

  initial begin
    int lat, bn, dn;
    fork
      model_loop();
      compare_loop();
    join_none

    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_q", 32'(out_q), 32'd0);
    chk("reset_flags", 32'({out_busy, out_done, out_divz, out_r}), 32'd0);

    step();
    run_op(4'd13, 4'd4, lat, bn);
    chk("13/4_latency", 32'(lat), 32'd5);
    chk("13/4_busy_cycles", 32'(bn), 32'd4);
    chk("13/4_q", 32'(out_q), 32'd3);
    chk("13/4_r", 32'(out_r), 32'd1);
    chk("13/4_divz", 32'(out_divz), 32'd0);
    chk("model_pin_13/4", 32'({m_q, m_r}), 32'h31);

    step(); run_op(4'd15, 4'd1, lat, bn);
    chk("15/1_qr", 32'({out_q, out_r}), 32'hF0);
    step(); run_op(4'd7, 4'd9, lat, bn);
    chk("7/9_qr", 32'({out_q, out_r}), 32'h07);
    step(); run_op(4'd0, 4'd5, lat, bn);
    chk("0/5_qr", 32'({out_q, out_r}), 32'h00);

    step(); run_op(4'd9, 4'd0, lat, bn);
    chk("9/0_latency", 32'(lat), 32'd1);
    chk("9/0_busy_cycles", 32'(bn), 32'd0);
    chk("9/0_qr", 32'({out_q, out_r}), 32'hF9);
    chk("9/0_divz", 32'(out_divz), 32'd1);
    step(); run_op(4'd8, 4'd2, lat, bn);
    chk("8/2_qr", 32'({out_q, out_r}), 32'h40);
    chk("8/2_divz", 32'(out_divz), 32'd0);

    // Start while busy must be ignored.
    step();
    in_a = 4'd13; in_b = 4'd4; in_start = 1'b1;
    step();
    in_start = 1'b0;
    step();
    in_a = 4'd12; in_b = 4'd5; in_start = 1'b1;
    step();
    in_start = 1'b0;
    wait_done(lat, bn);
    chk("busy_start_ignored_qr", 32'({out_q, out_r}), 32'h31);

    // Back-to-back: second start presented during the DONE cycle.
    step(); run_op(4'd13, 4'd4, lat, bn);
    in_a = 4'd14; in_b = 4'd3; in_start = 1'b1;
    step();
    in_start = 1'b0;
    wait_done(lat, bn);
    chk("b2b_latency", 32'(lat), 32'd5);
    chk("b2b_qr", 32'({out_q, out_r}), 32'h42);

    // Reset at RUN step 2 abandons the operation.
    step();
    in_a = 4'd13; in_b = 4'd4; in_start = 1'b1;
    step();
    in_start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_run_outputs", 32'({out_busy, out_done, out_divz, out_q, out_r}), 32'd0);
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_done) dn++;
    end
    chk("rst_mid_run_no_done", 32'(dn), 32'd0);
    step(); run_op(4'd6, 4'd4, lat, bn);
    chk("6/4_qr", 32'({out_q, out_r}), 32'h12);

    // Sweep of every nonzero-divisor pair.
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        step();
        run_op(W'(a), W'(b), lat, bn);
        chk("sweep_q", 32'(out_q), 32'(a / b));
        chk("sweep_r", 32'(out_r), 32'(a % b));
      end
    end

    step(); step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
